// File: rtl/mips_cpu_dmem_pkg.sv
// ---------------------------------------------------------------------------
// mips_cpu_dmem_pkg
// Shared definitions for the Harvard data-memory responder:
//   - byte offsets of the four MMIO registers inside the 16-byte MMIO window
//   - bit positions of the fields in the STATUS register
//   - the address-decode result type and a helper that maps an MMIO word
//     offset onto it
// ---------------------------------------------------------------------------
package mips_cpu_dmem_pkg;

  // Byte offsets within the MMIO block.
  localparam logic [3:0] OFF_CYCLES  = 4'h0;
  localparam logic [3:0] OFF_CONSOLE = 4'h4;
  localparam logic [3:0] OFF_STATUS  = 4'h8;
  localparam logic [3:0] OFF_ERRCLR  = 4'hC;

  // STATUS register layout.
  localparam int ST_ERR     = 0;
  localparam int ST_OVF     = 1;
  localparam int ST_FULL    = 2;
  localparam int ST_CNT_LSB = 4;
  localparam int ST_CNT_W   = 4;

  typedef enum logic [2:0] {
    DEC_RAM,
    DEC_CYCLES,
    DEC_CONSOLE,
    DEC_STATUS,
    DEC_ERRCLR,
    DEC_NONE
  } dec_e;

  // Map a word offset (byte offset bits [3:2]) inside the MMIO window to
  // the register it selects. All four word slots are populated.
  function automatic dec_e mmio_decode(input logic [1:0] word_off);
    dec_e d;
    case (word_off)
      OFF_CYCLES[3:2]:  d = DEC_CYCLES;
      OFF_CONSOLE[3:2]: d = DEC_CONSOLE;
      OFF_STATUS[3:2]:  d = DEC_STATUS;
      OFF_ERRCLR[3:2]:  d = DEC_ERRCLR;
      default:          d = DEC_NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mips_cpu_dmem_fifo.sv
// ---------------------------------------------------------------------------
// mips_cpu_dmem_fifo
// Small synchronous byte FIFO feeding the console TX port.
// Ports:
//   clk    in   clock, rising edge
//   reset  in   asynchronous, active-low; empties the FIFO, clears storage
//   push   in   write din at the tail this edge
//   pop    in   discard the head this edge (ignored when empty)
//   din    in   [7:0] byte to push
//   dout   out  [7:0] head byte, read from registered storage
//   empty  out  no entries
//   full   out  DEPTH entries
//   count  out  number of entries, 0..DEPTH
// A push while full is accepted only if a pop happens on the same edge; the
// caller is responsible for noticing the dropped-byte case.
// ---------------------------------------------------------------------------
module mips_cpu_dmem_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          push_ok;
  logic          pop_ok;
  logic [DEPTH-1:0] slot_we;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));
  assign count = count_reg;
  assign dout  = mem_reg[rd_ptr_reg];

  // When full, the tail slot is the head slot; writing it while the head is
  // popped on the same edge is safe because the old head is consumed.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot_we
      assign slot_we[gi] = push_ok && (wr_ptr_reg == AW'(gi));
    end
  endgenerate

  always_comb begin
    count_next = count_reg + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (slot_we[i]) begin
          mem_reg[i] <= din;
        end
      end
      // DEPTH is a power of two, so the pointers wrap on their own.
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/mips_cpu_harvard_dmem.sv
// ---------------------------------------------------------------------------
// mips_cpu_harvard_dmem
// Data-memory responder for the Harvard CPU's data port: a word RAM plus a
// 16-byte MMIO block (cycle counter, console TX FIFO, status, error clear).
// Ports:
//   clk             in   clock, rising edge
//   reset           in   asynchronous, active-low (RAM contents survive)
//   clk_enable      in   low freezes every piece of state
//   data_address    in   [31:0] byte address
//   data_write      in   store request
//   data_read       in   load request
//   data_writedata  in   [31:0] store data
//   data_readdata   out  [31:0] load data, combinational, 0 when not reading
//   tx_valid        out  console FIFO has a byte
//   tx_data         out  [7:0] console FIFO head byte
//   tx_ready        in   consumer takes the head byte this edge
//   err             out  sticky access-error flag
// ---------------------------------------------------------------------------
module mips_cpu_harvard_dmem
  import mips_cpu_dmem_pkg::*;
#(
  parameter logic [31:0] RAM_BASE   = 32'h0000_1000,
  parameter int unsigned RAM_WORDS  = 1024,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [31:0] data_address,
  input  logic        data_write,
  input  logic        data_read,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        err
);

  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

  logic [31:0]       ram_mem [RAM_WORDS];
  logic [RAM_AW-1:0] ram_idx;

  logic [31:0] cycle_reg;
  logic        err_reg;
  logic        ovf_reg;

  dec_e        dec;
  logic        misaligned;
  logic        access;
  logic        ro_write;
  logic        err_set;
  logic        store_ok;
  logic        ram_we;
  logic        err_clr;
  logic        ovf_event;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_count;

  logic [31:0] status_word;
  logic [31:0] rdata;

  // -------------------------------------------------------------------------
  // Address decode. RAM_BASE is aligned to the RAM size, so a hit is a match
  // on the bits above the word index.
  // -------------------------------------------------------------------------
  always_comb begin
    dec = DEC_NONE;
    if (data_address[31:RAM_AW+2] == RAM_BASE[31:RAM_AW+2]) begin
      dec = DEC_RAM;
    end else if (data_address[31:4] == MMIO_BASE[31:4]) begin
      dec = mmio_decode(data_address[3:2]);
    end
  end

  assign ram_idx    = data_address[RAM_AW+1:2];
  assign misaligned = |data_address[1:0];
  assign access     = data_read || data_write;
  assign ro_write   = data_write && ((dec == DEC_CYCLES) || (dec == DEC_STATUS));
  assign err_set    = (access && (misaligned || (dec == DEC_NONE))) || ro_write;

  // A misaligned or unmapped store only raises err; nothing else moves.
  assign store_ok  = data_write && !misaligned && clk_enable;
  assign ram_we    = store_ok && (dec == DEC_RAM);
  assign fifo_push = store_ok && (dec == DEC_CONSOLE);
  assign err_clr   = store_ok && (dec == DEC_ERRCLR);

  // The consumer is ignored while the block is frozen.
  assign fifo_pop  = clk_enable && tx_valid && tx_ready;
  assign ovf_event = fifo_push && fifo_full && !fifo_pop;

  // -------------------------------------------------------------------------
  // RAM: contents are deliberately not reset. Read is asynchronous so a load
  // and store to the same word in one cycle returns the old word.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_mem[ram_idx] <= data_writedata;
    end
  end

  // -------------------------------------------------------------------------
  // Free-running cycle counter; wraps naturally at 32 bits.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_reg <= '0;
    end else if (clk_enable) begin
      cycle_reg <= cycle_reg + 32'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Sticky error and overflow flags. A clear and a new error cannot come from
  // the same access (ERRCLR is a valid aligned target), so ordering is moot.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_reg <= 1'b0;
      ovf_reg <= 1'b0;
    end else if (clk_enable) begin
      if (err_clr) begin
        err_reg <= 1'b0;
        ovf_reg <= 1'b0;
      end else begin
        if (err_set) begin
          err_reg <= 1'b1;
        end
        if (ovf_event) begin
          ovf_reg <= 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Console FIFO.
  // -------------------------------------------------------------------------
  mips_cpu_dmem_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (data_writedata[7:0]),
    .dout  (tx_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign tx_valid = !fifo_empty;
  assign err      = err_reg;

  // -------------------------------------------------------------------------
  // Read path.
  // -------------------------------------------------------------------------
  always_comb begin
    status_word = '0;
    status_word[ST_ERR]  = err_reg;
    status_word[ST_OVF]  = ovf_reg;
    status_word[ST_FULL] = fifo_full;
    status_word[ST_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(fifo_count);
  end

  always_comb begin
    rdata = '0;
    if (data_read && !misaligned) begin
      case (dec)
        DEC_RAM:    rdata = ram_mem[ram_idx];
        DEC_CYCLES: rdata = cycle_reg;
        DEC_STATUS: rdata = status_word;
        default:    rdata = '0;
      endcase
    end
  end

  assign data_readdata = rdata;

endmodule

// File: tb/tb_mips_cpu_harvard_dmem.sv
// ---------------------------------------------------------------------------
// tb_mips_cpu_harvard_dmem
// Self-checking bench for mips_cpu_harvard_dmem: a directed vector table,
// hand-written counter / FIFO / reset sequences and a randomized run, all
// compared against a behavioural model (associative RAM, byte queue,
// plain counter and flags).
// ---------------------------------------------------------------------------
module tb_mips_cpu_harvard_dmem;

  localparam logic [31:0] RAM_BASE   = 32'h0000_1000;
  localparam int          RAM_WORDS  = 1024;
  localparam logic [31:0] MMIO_BASE  = 32'hFFFF_0000;
  localparam int          FIFO_DEPTH = 4;

  localparam logic [31:0] A_CYC  = 32'hFFFF_0000;
  localparam logic [31:0] A_CON  = 32'hFFFF_0004;
  localparam logic [31:0] A_STAT = 32'hFFFF_0008;
  localparam logic [31:0] A_CLR  = 32'hFFFF_000C;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic [31:0] data_address;
  logic        data_write;
  logic        data_read;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        err;

  always #5 clk = ~clk;

  mips_cpu_harvard_dmem dut (
    .clk            (clk),
    .reset          (reset),
    .clk_enable     (clk_enable),
    .data_address   (data_address),
    .data_write     (data_write),
    .data_read      (data_read),
    .data_writedata (data_writedata),
    .data_readdata  (data_readdata),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .tx_ready       (tx_ready),
    .err            (err)
  );

  int tests = 0;
  int fails = 0;

  // Behavioural model state.
  logic [31:0] m_ram [int];
  logic [31:0] m_cycles;
  logic [7:0]  m_q [$];
  logic        m_err;
  logic        m_ovf;
  logic [7:0]  popped [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // 0 RAM, 1 CYCLES, 2 CONSOLE, 3 STATUS, 4 ERRCLR, 5 unmapped
  function automatic int region(input logic [31:0] a);
    if (a >= RAM_BASE && a < RAM_BASE + 32'(4 * RAM_WORDS)) return 0;
    if (a >= MMIO_BASE && a < MMIO_BASE + 32'd16) return 1 + int'((a - MMIO_BASE) >> 2);
    return 5;
  endfunction

  function automatic logic [31:0] m_status();
    int n;
    n = m_q.size();
    return (m_err ? 32'd1 : 32'd0) + (m_ovf ? 32'd2 : 32'd0) +
           ((n == FIFO_DEPTH) ? 32'd4 : 32'd0) + 32'(n * 16);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input logic rd, output logic known);
    int r;
    int idx;
    known = 1'b1;
    if (!rd || a[1:0] != 2'b00) return 32'd0;
    r = region(a);
    case (r)
      0: begin
        idx = int'((a - RAM_BASE) >> 2);
        if (m_ram.exists(idx)) return m_ram[idx];
        known = 1'b0;
        return 32'd0;
      end
      1: return m_cycles;
      3: return m_status();
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_update(input logic [31:0] a, input logic rd, input logic wr,
                          input logic [31:0] wd, input logic en, input logic rdy);
    int   r;
    logic mis;
    logic pop;
    logic was_full;
    logic [7:0] junk;
    if (!en) return;
    r   = region(a);
    mis = (a[1:0] != 2'b00);
    m_cycles = m_cycles + 32'd1;
    if ((rd || wr) && (mis || r == 5)) m_err = 1'b1;
    if (wr && (r == 1 || r == 3)) m_err = 1'b1;
    pop      = rdy && (m_q.size() > 0);
    was_full = (m_q.size() == FIFO_DEPTH);
    if (pop) junk = m_q.pop_front();
    if (wr && !mis) begin
      case (r)
        0: m_ram[int'((a - RAM_BASE) >> 2)] = wd;
        2: begin
          if (was_full && !pop) m_ovf = 1'b1;
          else m_q.push_back(wd[7:0]);
        end
        4: begin
          m_err = 1'b0;
          m_ovf = 1'b0;
        end
        default: ;
      endcase
    end
  endtask

  // One bus transaction. Called right after a falling edge; drives inputs,
  // samples outputs before the rising edge, advances the model on it and
  // returns at the following falling edge.
  task automatic do_cycle(input logic [31:0] a, input logic rd, input logic wr,
                          input logic [31:0] wd, input logic en, input logic rdy,
                          output logic [31:0] rdata);
    logic        known;
    logic [31:0] exp;
    data_address   = a;
    data_read      = rd;
    data_write     = wr;
    data_writedata = wd;
    clk_enable     = en;
    tx_ready       = rdy;
    #2;
    rdata = data_readdata;
    exp   = m_read(a, rd, known);
    $display("[TB] addr=%h rd=%0b wr=%0b wd=%h en=%0b rdy=%0b rdata=%h txv=%0b txd=%h err=%0b",
             a, rd, wr, wd, en, rdy, rdata, tx_valid, tx_data, err);
    if (known) check("readdata", rdata, exp);
    check("tx_valid", 32'(tx_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) check("tx_data", 32'(tx_data), 32'(m_q[0]));
    check("err", 32'(err), 32'(m_err));
    if (en && rdy && m_q.size() > 0) popped.push_back(tx_data);
    @(posedge clk);
    m_update(a, rd, wr, wd, en, rdy);
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [$];

  initial begin
    logic [31:0] rv;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [7:0]  exp_bytes [$];
    logic [31:0] ra;
    int          sel;

    reset = 1'b0; clk_enable = 1'b0; data_address = '0; data_write = 1'b0;
    data_read = 1'b0; data_writedata = '0; tx_ready = 1'b0;
    m_cycles = '0; m_err = 1'b0; m_ovf = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    data_address = A_STAT; data_read = 1'b1;
    #1;
    check("rst_status", data_readdata, 32'd0);
    data_address = A_CYC;
    #1;
    check("rst_cycles", data_readdata, 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    data_read = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // ---------------- directed vector table ----------------
    vecs.push_back('{32'h0000_1004, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0,         1'b0});
    vecs.push_back('{32'h0000_1004, 1'b1, 1'b0, 32'h0,        32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{32'h0000_1004, 1'b1, 1'b1, 32'h1,        32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{32'h0000_1004, 1'b1, 1'b0, 32'h0,        32'h1,         1'b0});
    vecs.push_back('{32'h0000_1002, 1'b0, 1'b1, 32'h55,       32'h0,         1'b0});
    vecs.push_back('{32'h0000_1004, 1'b1, 1'b0, 32'h0,        32'h1,         1'b1});
    vecs.push_back('{A_CLR,         1'b0, 1'b1, 32'h0,        32'h0,         1'b1});
    vecs.push_back('{A_STAT,        1'b1, 1'b0, 32'h0,        32'h0,         1'b0});
    vecs.push_back('{32'h0000_0010, 1'b1, 1'b0, 32'h0,        32'h0,         1'b0});
    vecs.push_back('{A_STAT,        1'b1, 1'b0, 32'h0,        32'h1,         1'b1});
    vecs.push_back('{A_CLR,         1'b0, 1'b1, 32'h0,        32'h0,         1'b1});
    vecs.push_back('{A_CYC,         1'b0, 1'b1, 32'h0,        32'h0,         1'b0});
    vecs.push_back('{A_CON,         1'b1, 1'b0, 32'h0,        32'h0,         1'b1});
    vecs.push_back('{A_CLR,         1'b0, 1'b1, 32'h0,        32'h0,         1'b1});
    vecs.push_back('{32'h0000_1FFC, 1'b0, 1'b1, 32'h1234_5678, 32'h0,        1'b0});
    vecs.push_back('{32'h0000_1FFC, 1'b1, 1'b0, 32'h0,        32'h1234_5678, 1'b0});
    vecs.push_back('{32'h0000_2000, 1'b1, 1'b0, 32'h0,        32'h0,         1'b0});
    vecs.push_back('{A_STAT,        1'b1, 1'b0, 32'h0,        32'h1,         1'b1});
    vecs.push_back('{A_CLR,         1'b0, 1'b1, 32'h0,        32'h0,         1'b1});
    vecs.push_back('{32'h0000_0FFC, 1'b1, 1'b0, 32'h0,        32'h0,         1'b0});
    vecs.push_back('{32'hFFFF_0010, 1'b1, 1'b0, 32'h0,        32'h0,         1'b1});
    vecs.push_back('{A_CLR,         1'b0, 1'b1, 32'h0,        32'h0,         1'b1});
    vecs.push_back('{A_STAT,        1'b0, 1'b1, 32'h7,        32'h0,         1'b0});
    vecs.push_back('{A_STAT,        1'b1, 1'b0, 32'h0,        32'h1,         1'b1});
    vecs.push_back('{A_CLR,         1'b0, 1'b1, 32'h0,        32'h0,         1'b1});
    vecs.push_back('{32'h0000_1004, 1'b0, 1'b0, 32'h0,        32'h0,         1'b0});
    vecs.push_back('{32'hFFFF_0009, 1'b1, 1'b0, 32'h0,        32'h0,         1'b0});
    vecs.push_back('{A_CLR,         1'b0, 1'b1, 32'h0,        32'h0,         1'b1});

    foreach (vecs[i]) begin
      check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
      do_cycle(vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].wdata, 1'b1, 1'b1, rv);
      check($sformatf("vec%0d_rd", i), rv, vecs[i].exp_rd);
    end

    // ---------------- cycle counter ----------------
    do_cycle(A_CYC, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, a0);
    repeat (7) do_cycle(32'h0000_1004, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, rv);
    do_cycle(A_CYC, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, b0);
    check("cycles_delta_8", b0 - a0, 32'd8);

    do_cycle(A_CYC, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, a0);
    repeat (5) do_cycle(32'h0000_1004, 1'b0, 1'b1, 32'h99, 1'b0, 1'b1, rv);
    do_cycle(A_CYC, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, b0);
    check("cycles_frozen", b0 - a0, 32'd1);
    do_cycle(32'h0000_1004, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, rv);
    check("frozen_store_ignored", rv, 32'h1);

    force dut.cycle_reg = 32'hFFFF_FFFE;
    #1;
    release dut.cycle_reg;
    m_cycles = 32'hFFFF_FFFE;
    do_cycle(A_CYC, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, rv);
    check("cycles_fffffffe", rv, 32'hFFFF_FFFE);
    do_cycle(A_CYC, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, rv);
    check("cycles_ffffffff", rv, 32'hFFFF_FFFF);
    do_cycle(A_CYC, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, rv);
    check("cycles_wrap", rv, 32'h0);

    // ---------------- console FIFO ----------------
    for (int b = 8'h41; b <= 8'h45; b++) begin
      do_cycle(A_CON, 1'b0, 1'b1, 32'(b), 1'b1, 1'b0, rv);
    end
    do_cycle(A_STAT, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, rv);
    check("status_full_ovf", rv, 32'h46);
    check("head_0x41", 32'(tx_data), 32'h41);
    popped.delete();
    do_cycle(A_CON, 1'b0, 1'b1, 32'h46, 1'b1, 1'b1, rv);
    do_cycle(A_STAT, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, rv);
    check("status_push_pop_full", rv, 32'h46);
    for (int i = 0; i < 10 && tx_valid; i++) begin
      do_cycle(32'h0000_1004, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, rv);
    end
    check("drained_tx_valid", 32'(tx_valid), 32'd0);
    exp_bytes = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h46};
    check("drain_count", 32'(popped.size()), 32'd5);
    foreach (exp_bytes[i]) begin
      if (i < popped.size()) check($sformatf("drain_byte%0d", i), 32'(popped[i]), 32'(exp_bytes[i]));
    end
    do_cycle(A_CLR, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, rv);
    do_cycle(A_STAT, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, rv);
    check("status_after_clr", rv, 32'h0);

    // ---------------- reset mid-burst ----------------
    for (int b = 8'h61; b <= 8'h63; b++) begin
      do_cycle(A_CON, 1'b0, 1'b1, 32'(b), 1'b1, 1'b0, rv);
    end
    check("burst_tx_valid", 32'(tx_valid), 32'd1);
    data_write = 1'b0; data_read = 1'b0; tx_ready = 1'b1;
    reset = 1'b0;
    #1;
    check("async_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("async_rst_tx_data", 32'(tx_data), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    m_q.delete(); m_err = 1'b0; m_ovf = 1'b0; m_cycles = '0;
    do_cycle(A_STAT, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, rv);
    check("status_after_reset", rv, 32'h0);
    do_cycle(32'h0000_1004, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, rv);
    check("ram_kept_over_reset", rv, 32'h1);

    // ---------------- randomized traffic ----------------
    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 11));
      case (sel)
        0, 1, 2, 3: ra = RAM_BASE + 32'(4 * $urandom_range(0, 15));
        4, 5, 6:    ra = MMIO_BASE + 32'(4 * $urandom_range(0, 3));
        7:          ra = A_CLR;
        8:          ra = A_CON;
        9:          ra = 32'h0000_2000 + 32'(4 * $urandom_range(0, 3));
        10:         ra = RAM_BASE + 32'($urandom_range(1, 3));
        default:    ra = MMIO_BASE + 32'd16 + 32'(4 * $urandom_range(0, 3));
      endcase
      do_cycle(ra, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
               1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), rv);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
